// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled 8N1 UART receiver driven by an s_tick enable.
// Define UART_RX_PARITY_EN to add an even-parity bit and a parity_err output.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       s_tick,
    output logic [7:0] dout,
    output logic       rx_done_tick,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       frame_err
);
    localparam int SW = (SB_TICK > 16) ? 5 : 4;
    localparam logic [2:0] N_LAST = 3'(DBIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [2:0] n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [7:0] dout_q, dout_d;
    logic done_q, done_d;
    logic ferr_q, ferr_d;
    logic rx_s1_q, rx_s2_q;
    logic rx_s;
`ifdef UART_RX_PARITY_EN
    logic pbad_q, pbad_d;
    logic perr_q, perr_d;
`endif

    assign rx_s = rx_s2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
            pbad_q  <= pbad_d;
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
        pbad_d  = pbad_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == SW'(7)) begin
                        // A start bit that is high again at its centre is a glitch
                        state_d = rx_s ? IDLE : DATA;
                        s_d     = '0;
                        n_d     = '0;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d = '0;
                        b_d = DBIT'({rx_s, b_q} >> 1);
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_q == SW'(15)) begin
                        s_d     = '0;
                        pbad_d  = rx_s ^ (^b_q);
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_q == SW'(SB_TICK - 1)) begin
                        state_d = IDLE;
                        dout_d  = 8'(b_q);
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = pbad_q;
`endif
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; expected frames are queued by
// the stimulus process and checked by a monitor on every rx_done_tick.
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       s_tick;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_bad = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    uart_rx dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
`ifdef UART_RX_PARITY_EN
        .parity_err   (parity_err),
`endif
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // One s_tick every 4 clocks, changed on the falling edge
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rx_done_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got dout=%h with no frame pending", dout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("dout", dout, e.d);
                check("frame_err", {7'd0, frame_err}, {7'd0, e.fe});
`ifdef UART_RX_PARITY_EN
                check("parity_err", {7'd0, parity_err}, {7'd0, e.pe});
`endif
            end
        end
    end

    task automatic tick_wait(input int k);
        int i;
        i = 0;
        while (i < k) begin
            @(posedge clk);
            if (s_tick) i++;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        tick_wait(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick_wait(16);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_bad;
        tick_wait(16);
`endif
        rx = stop;
        tick_wait(10);
        rx = 1'b1;
        tick_wait(16);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic fe, input logic pe);
        exp_t e;
        e.d  = d;
        e.fe = fe;
        e.pe = pe;
        exp_q.push_back(e);
    endtask

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_dout", dout, 8'h00);
        check("reset_done", {7'd0, rx_done_tick}, 8'h00);
        check("reset_ferr", {7'd0, frame_err}, 8'h00);
        tick_wait(200);

        expect_frame(8'h55, 1'b0, 1'b0);
        send(8'h55, 1'b1);
        expect_frame(8'hA3, 1'b0, 1'b0);
        send(8'hA3, 1'b1);

        rx = 1'b0;
        tick_wait(4);
        rx = 1'b1;
        tick_wait(30);
        check("glitch_dout", dout, 8'hA3);

        expect_frame(8'hF0, 1'b1, 1'b0);
        send(8'hF0, 1'b0);
        expect_frame(8'h0F, 1'b0, 1'b0);
        send(8'h0F, 1'b1);

        // 0xC3 aborted by reset part-way through data bit 4
        rx = 1'b0;
        tick_wait(16);
        for (int i = 0; i < 4; i++) begin
            rx = (i < 2) ? 1'b1 : 1'b0;
            tick_wait(16);
        end
        rx = 1'b0;
        tick_wait(8);
        reset = 1'b0;
        rx    = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_dout", dout, 8'h00);
        check("abort_ferr", {7'd0, frame_err}, 8'h00);
        reset = 1'b1;
        tick_wait(40);
        expect_frame(8'h3C, 1'b0, 1'b0);
        send(8'h3C, 1'b1);

`ifdef UART_RX_PARITY_EN
        par_bad = 1'b0;
        expect_frame(8'h07, 1'b0, 1'b0);
        send(8'h07, 1'b1);
        par_bad = 1'b1;
        expect_frame(8'h07, 1'b0, 1'b1);
        send(8'h07, 1'b1);
        par_bad = 1'b0;
`endif

        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
        check("pending_frames", 8'(exp_q.size()), 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
